fetch_unit: RTL

- Instruction-fetch stage of the ARM968E-S-style 5-stage pipeline.
- Owns the program counter and drives the address into the combinational instruction memory.
- Captures the returned instruction word into the IF/ID pipeline register.
- Handles hazard-unit freeze, branch redirect/flush and synchronous reset; feeds the decode stage.

---
 rtl/fetch_unit_pkg.sv | 24 ++
 rtl/fetch_unit_if.sv | 37 +++
 rtl/fetch_unit_pc_register.sv | 34 +++
 rtl/fetch_unit.sv | 77 +++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared pipeline definitions for the fetch stage and its neighbours.
// Optional performance counters are enabled with the FETCH_PERF_CNT_EN macro.
package fetch_unit_pkg;

  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH  = 32;
  localparam int unsigned PC_STEP     = 4;

  // An all-zero word is treated as a bubble by decode.
  localparam logic [INSTR_WIDTH-1:0] NOP_WORD = 32'h0;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instruction;
    logic                   valid;
  } if_id_t;

  typedef enum logic [1:0] {
    PcHold = 2'd0,
    PcInc  = 2'd1,
    PcLoad = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: hazard/branch control in, instruction memory, and IF/ID outputs.
// FETCH_PERF_CNT_EN adds the fetch_count / bubble_count signals.
interface fetch_unit_if #(
  parameter int unsigned DATA_LEN    = 32,
  parameter int unsigned ADDRESS_LEN = 32
) ();

  logic                   freeze;
  logic                   branch_taken;
  logic [ADDRESS_LEN-1:0] branch_address;
  logic [ADDRESS_LEN-1:0] imem_address;
  logic [DATA_LEN-1:0]    imem_data;
  logic [ADDRESS_LEN-1:0] pc_out;
  logic [DATA_LEN-1:0]    instruction_out;
  logic                   valid_out;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]            fetch_count;
  logic [31:0]            bubble_count;
`endif

  modport master (
    input  freeze, branch_taken, branch_address, imem_data,
    output imem_address, pc_out, instruction_out, valid_out
`ifdef FETCH_PERF_CNT_EN
    , output fetch_count, bubble_count
`endif
  );

  modport slave (
    output freeze, branch_taken, branch_address, imem_data,
    input  imem_address, pc_out, instruction_out, valid_out
`ifdef FETCH_PERF_CNT_EN
    , input fetch_count, bubble_count
`endif
  );

endinterface

// File: rtl/fetch_unit_pc_register.sv
// Program counter with hold / increment / load select and synchronous reset.
module fetch_unit_pc_register
  import fetch_unit_pkg::*;
#(
  parameter int unsigned          ADDRESS_LEN = ADDR_WIDTH,
  parameter logic [ADDRESS_LEN-1:0] RESET_PC  = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  pc_sel_e                sel,
  input  logic [ADDRESS_LEN-1:0] load_value,
  output logic [ADDRESS_LEN-1:0] pc,
  output logic [ADDRESS_LEN-1:0] pc_plus4
);

  logic [ADDRESS_LEN-1:0] pc_q;

  // Wraps modulo 2^ADDRESS_LEN by construction.
  assign pc_plus4 = pc_q + ADDRESS_LEN'(PC_STEP);
  assign pc       = pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      case (sel)
        PcLoad:  pc_q <= load_value;
        PcInc:   pc_q <= pc_plus4;
        default: pc_q <= pc_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives instruction memory, fills IF/ID.
// Defining FETCH_PERF_CNT_EN adds fetch and bubble counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned            DATA_LEN    = INSTR_WIDTH,
  parameter int unsigned            ADDRESS_LEN = ADDR_WIDTH,
  parameter logic [ADDRESS_LEN-1:0] RESET_PC    = '0
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  logic [ADDRESS_LEN-1:0] pc;
  logic [ADDRESS_LEN-1:0] pc_plus4;
  logic [ADDRESS_LEN-1:0] branch_target;
  pc_sel_e                pc_sel;
  if_id_t                 if_id_q;

  assign branch_target = bus.branch_address & {{(ADDRESS_LEN-2){1'b1}}, 2'b00};

  // Branch beats freeze; reset is applied inside the PC register.
  always_comb begin
    pc_sel = PcInc;
    if (bus.branch_taken) begin
      pc_sel = PcLoad;
    end else if (bus.freeze) begin
      pc_sel = PcHold;
    end
  end

  fetch_unit_pc_register #(
    .ADDRESS_LEN (ADDRESS_LEN),
    .RESET_PC    (RESET_PC)
  ) u_pc_register (
    .clk        (clk),
    .rst        (rst),
    .sel        (pc_sel),
    .load_value (branch_target),
    .pc         (pc),
    .pc_plus4   (pc_plus4)
  );

  always_ff @(posedge clk) begin
    if (rst || bus.branch_taken) begin
      if_id_q <= '{pc: '0, instruction: NOP_WORD, valid: 1'b0};
    end else if (!bus.freeze) begin
      if_id_q <= '{pc: pc_plus4, instruction: bus.imem_data, valid: 1'b1};
    end
  end

  assign bus.imem_address    = pc;
  assign bus.pc_out          = if_id_q.pc;
  assign bus.instruction_out = DATA_LEN'(if_id_q.instruction);
  assign bus.valid_out       = if_id_q.valid;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q;
  logic [31:0] bubble_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q  <= '0;
      bubble_count_q <= '0;
    end else if (bus.branch_taken || bus.freeze) begin
      bubble_count_q <= bubble_count_q + 32'd1;
    end else begin
      fetch_count_q  <= fetch_count_q + 32'd1;
    end
  end

  assign bus.fetch_count  = fetch_count_q;
  assign bus.bubble_count = bubble_count_q;
`endif

endmodule
